// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RV32I controller, datapath ALU and data RAM.
// Holds FSM state codes, ALU operation codes, memory access sizes, PC source codes and opcodes.
package multicycle_control_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_BYTE = 2'b01;
    localparam logic [1:0] DT_HALF = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/multicycle_control_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/J/U layout from the opcode
// and sign-extends the result to the datapath width.
module imm_gen
    import multicycle_control_pkg::*;
#(
    parameter int Data_Width = 32
) (
    input  logic [31:0]           instr,
    output logic [Data_Width-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OP_IALU, OP_LOAD, OP_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_LUI:
                imm32 = {instr[31:12], 12'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = Data_Width'($signed(imm32));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: accepts one instruction in IDLE, walks it through
// DECODE/EXECUTE/MEM/WB and issues the datapath controls and one-cycle strobes.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int Data_Width            = 32,
    parameter int Address_Width_RegFile = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      instr,
    input  logic                             instr_valid,
    output logic                             instr_ready,
    input  logic                             eq,
    output logic [Address_Width_RegFile-1:0] rs1,
    output logic [Address_Width_RegFile-1:0] rs2,
    output logic [Address_Width_RegFile-1:0] rd,
    output logic                             regFileWen,
    output logic                             ALUSrc,
    output logic [Data_Width-1:0]            ImmOp,
    output logic [3:0]                       ALU_ctrl,
    output logic                             MemWrite,
    output logic [1:0]                       dataType,
    output logic                             SrcSel,
    output logic                             JumpSel,
    output logic                             pc_en,
    output logic [1:0]                       pc_sel,
    output logic                             illegal
);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [31:0]           ir;
    logic [Data_Width-1:0] imm_raw;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic       legal;
    logic       branch_taken;
    logic [3:0] alu_dec;
    logic [1:0] dtype_dec;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign f7b5      = ir[30];
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_IALU);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign legal     = is_legal_opcode(opcode);

    // Only BEQ and BNE are supported; any other branch funct3 falls through to PC+4.
    assign branch_taken = ((funct3 == 3'b000) && eq) || ((funct3 == 3'b001) && !eq);

    imm_gen #(.Data_Width(Data_Width)) u_imm_gen (
        .instr (ir),
        .imm   (imm_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && instr_valid) begin
                ir <= instr;
            end
        end
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:    state_next = instr_valid ? S_DECODE : S_IDLE;
            S_DECODE:  state_next = legal ? S_EXECUTE : S_IDLE;
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else if (is_branch) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM:     state_next = is_store ? S_IDLE : S_WB;
            S_WB:      state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Shift-right immediates reuse bit 30 to select arithmetic; only R-type uses it for SUB.
    always_comb begin
        alu_dec = ALU_ADD;
        if (is_branch) begin
            alu_dec = ALU_SUB;
        end else if (is_r || is_i) begin
            case (funct3)
                3'b000:  alu_dec = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_dec = ALU_SLL;
                3'b010:  alu_dec = ALU_SLT;
                3'b011:  alu_dec = ALU_SLTU;
                3'b100:  alu_dec = ALU_XOR;
                3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_dec = ALU_OR;
                default: alu_dec = ALU_AND;
            endcase
        end
    end

    always_comb begin
        dtype_dec = DT_WORD;
        if (is_load || is_store) begin
            case (funct3[1:0])
                2'b00:   dtype_dec = DT_BYTE;
                2'b01:   dtype_dec = DT_HALF;
                default: dtype_dec = DT_WORD;
            endcase
        end
    end

    // Every output is forced to 0 while rst is high, so an aborted store or write-back never strobes.
    always_comb begin
        rs1         = '0;
        rs2         = '0;
        rd          = '0;
        ImmOp       = '0;
        ALU_ctrl    = ALU_ADD;
        ALUSrc      = 1'b0;
        dataType    = DT_WORD;
        SrcSel      = 1'b0;
        JumpSel     = 1'b0;
        instr_ready = 1'b0;
        regFileWen  = 1'b0;
        MemWrite    = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = PC_PLUS4;
        illegal     = 1'b0;
        if (!rst) begin
            rs1      = is_lui ? '0 : Address_Width_RegFile'(ir[19:15]);
            rs2      = Address_Width_RegFile'(ir[24:20]);
            rd       = Address_Width_RegFile'(ir[11:7]);
            ImmOp    = imm_raw;
            ALU_ctrl = alu_dec;
            ALUSrc   = is_i || is_load || is_store || is_jalr || is_lui;
            dataType = dtype_dec;
            SrcSel   = is_load;
            JumpSel  = is_jal || is_jalr;
            case (state)
                S_IDLE:    instr_ready = 1'b1;
                S_DECODE:  illegal = !legal;
                S_EXECUTE: begin
                    if (is_branch) begin
                        pc_en  = 1'b1;
                        pc_sel = branch_taken ? PC_BRANCH : PC_PLUS4;
                    end
                end
                S_MEM: begin
                    if (is_store) begin
                        MemWrite = 1'b1;
                        pc_en    = 1'b1;
                        pc_sel   = PC_PLUS4;
                    end
                end
                S_WB: begin
                    regFileWen = (ir[11:7] != 5'd0);
                    pc_en      = 1'b1;
                    if (is_jal) begin
                        pc_sel = PC_BRANCH;
                    end else if (is_jalr) begin
                        pc_sel = PC_ALU;
                    end else begin
                        pc_sel = PC_PLUS4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed RV32I cases plus random instructions
// compared cycle by cycle against a behavioural model of the instruction timing and decode.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        eq = 1'b0;
    logic [4:0]  rs1, rs2, rd;
    logic        regFileWen, ALUSrc, MemWrite, SrcSel, JumpSel, pc_en, illegal;
    logic [31:0] ImmOp;
    logic [3:0]  ALU_ctrl;
    logic [1:0]  dataType, pc_sel;

    int checks = 0;
    int errors = 0;
    logic [31:0] curInstr = '0;

    always #5 clk = ~clk;

    multicycle_control #(.Data_Width(32), .Address_Width_RegFile(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .eq(eq), .rs1(rs1), .rs2(rs2), .rd(rd),
        .regFileWen(regFileWen), .ALUSrc(ALUSrc), .ImmOp(ImmOp), .ALU_ctrl(ALU_ctrl),
        .MemWrite(MemWrite), .dataType(dataType), .SrcSel(SrcSel), .JumpSel(JumpSel),
        .pc_en(pc_en), .pc_sel(pc_sel), .illegal(illegal)
    );

    // Expected behaviour of one instruction, derived from the ISA rules rather than the FSM.
    typedef struct {
        bit          legal;
        int          lat;
        bit          wb;
        bit          store;
        bit          chkAlu, chkSrc, chkDt, chkImm, chkRs1, chkRs2, chkRd;
        logic [3:0]  alu;
        bit          alusrc;
        logic [1:0]  dt;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        bit          srcsel, jumpsel;
        logic [1:0]  pcsel;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input logic e);
        exp_t x;
        logic [2:0] f3 = ins[14:12];
        logic [11:0] iimm = ins[31:20];
        logic [11:0] simm = {ins[31:25], ins[11:7]};
        logic [12:0] bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [20:0] jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        logic [3:0] aluTab [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        x = '{default: 0};
        x.legal = 1; x.rs1 = ins[19:15]; x.rs2 = ins[24:20]; x.rd = ins[11:7];
        x.alu = 4'd0; x.chkAlu = 1; x.chkImm = 1; x.chkRs1 = 1;
        case (ins[6:0])
            7'h33: begin
                x.lat = 3; x.wb = 1; x.chkRs2 = 1; x.chkRd = 1; x.chkImm = 0; x.chkSrc = 1;
                x.alu = aluTab[f3];
                if (ins[30] && f3 == 3'd0) x.alu = 4'd1;
                if (ins[30] && f3 == 3'd5) x.alu = 4'd7;
            end
            7'h13: begin
                x.lat = 3; x.wb = 1; x.chkRd = 1; x.chkSrc = 1; x.alusrc = 1;
                x.alu = aluTab[f3];
                if (ins[30] && f3 == 3'd5) x.alu = 4'd7;
                x.imm = 32'(signed'(iimm));
            end
            7'h03: begin
                x.lat = 4; x.wb = 1; x.chkRd = 1; x.chkSrc = 1; x.alusrc = 1; x.srcsel = 1;
                x.chkDt = 1; x.dt = (f3[1:0] == 2'd0) ? 2'b01 : (f3[1:0] == 2'd1) ? 2'b10 : 2'b00;
                x.imm = 32'(signed'(iimm));
            end
            7'h23: begin
                x.lat = 3; x.store = 1; x.chkRs2 = 1; x.chkSrc = 1; x.alusrc = 1;
                x.chkDt = 1; x.dt = (f3[1:0] == 2'd0) ? 2'b01 : (f3[1:0] == 2'd1) ? 2'b10 : 2'b00;
                x.imm = 32'(signed'(simm));
            end
            7'h63: begin
                x.lat = 2; x.chkRs2 = 1; x.chkSrc = 1; x.alu = 4'd1;
                x.pcsel = (((f3 == 3'd0) && e) || ((f3 == 3'd1) && !e)) ? 2'b01 : 2'b00;
                x.imm = 32'(signed'(bimm));
            end
            7'h6F: begin
                x.lat = 3; x.wb = 1; x.chkRd = 1; x.chkAlu = 0; x.chkRs1 = 0;
                x.jumpsel = 1; x.pcsel = 2'b01; x.imm = 32'(signed'(jimm));
            end
            7'h67: begin
                x.lat = 3; x.wb = 1; x.chkRd = 1; x.jumpsel = 1; x.pcsel = 2'b10;
                x.imm = 32'(signed'(iimm));
            end
            7'h37: begin
                x.lat = 3; x.wb = 1; x.chkRd = 1; x.rs1 = 5'd0; x.imm = {ins[31:12], 12'h000};
            end
            default: begin
                x.legal = 0; x.lat = 1;
            end
        endcase
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s instr=%08h got=%0h expected=%0h at %0t", tag, curInstr, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] r2, r1,
                                         input logic [2:0] f3, input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'h33};
    endfunction
    function automatic logic [31:0] encI(input logic [11:0] im, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {im, r1, f3, d, op};
    endfunction
    function automatic logic [31:0] encS(input logic [11:0] im, input logic [4:0] r2, r1, input logic [2:0] f3);
        return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] encB(input logic [12:0] im, input logic [4:0] r2, r1, input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] encJ(input logic [20:0] im, input logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
    endfunction

    // Called at a falling edge with the controller idle; leaves it idle at a falling edge.
    task automatic applyStimulus(input logic [31:0] ins, input logic e);
        exp_t x = model(ins, e);
        curInstr = ins;
        checkOutput("ready_before", {31'd0, instr_ready}, 32'd1);
        instr = ins; instr_valid = 1'b1; eq = e;
        for (int k = 1; k <= x.lat + 1; k++) begin
            @(negedge clk);
            if (k <= x.lat) begin
                checkOutput("instr_ready", {31'd0, instr_ready}, 32'd0);
                checkOutput("pc_en", {31'd0, pc_en}, {31'd0, x.legal && k == x.lat});
                checkOutput("regFileWen", {31'd0, regFileWen}, {31'd0, x.wb && k == x.lat && x.rd != 5'd0});
                checkOutput("MemWrite", {31'd0, MemWrite}, {31'd0, x.store && k == x.lat});
                checkOutput("illegal", {31'd0, illegal}, {31'd0, !x.legal && k == 1});
                if (x.legal) begin
                    if (k == x.lat) checkOutput("pc_sel", {30'd0, pc_sel}, {30'd0, x.pcsel});
                    if (x.chkImm) checkOutput("ImmOp", ImmOp, x.imm);
                    if (x.chkAlu) checkOutput("ALU_ctrl", {28'd0, ALU_ctrl}, {28'd0, x.alu});
                    if (x.chkSrc) checkOutput("ALUSrc", {31'd0, ALUSrc}, {31'd0, x.alusrc});
                    if (x.chkDt) checkOutput("dataType", {30'd0, dataType}, {30'd0, x.dt});
                    if (x.chkRs1) checkOutput("rs1", {27'd0, rs1}, {27'd0, x.rs1});
                    if (x.chkRs2) checkOutput("rs2", {27'd0, rs2}, {27'd0, x.rs2});
                    if (x.chkRd) checkOutput("rd", {27'd0, rd}, {27'd0, x.rd});
                    if (x.wb) begin
                        checkOutput("SrcSel", {31'd0, SrcSel}, {31'd0, x.srcsel});
                        checkOutput("JumpSel", {31'd0, JumpSel}, {31'd0, x.jumpsel});
                    end
                end
                // Junk offered mid-instruction must be ignored; stop offering on the last cycle.
                if (k < x.lat) begin
                    instr_valid = 1'($urandom_range(0, 1));
                    instr = $urandom;
                end else begin
                    instr_valid = 1'b0;
                end
            end else begin
                checkOutput("ready_after", {31'd0, instr_ready}, 32'd1);
                checkOutput("pc_en_idle", {31'd0, pc_en}, 32'd0);
            end
        end
    endtask

    function automatic logic [31:0] randomInstr();
        int kind = $urandom_range(0, 8);
        logic [4:0] r1 = 5'($urandom), r2 = 5'($urandom), d = 5'($urandom);
        logic [2:0] f3 = 3'($urandom);
        logic [11:0] im = 12'($urandom);
        logic [2:0] ldTab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [6:0] op;
        case (kind)
            0: return encR(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2, r1, f3, d);
            1: begin
                if (f3 == 3'd1) im[11:5] = 7'h00;
                if (f3 == 3'd5) im[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return encI(im, r1, f3, d, 7'h13);
            end
            2: return encI(im, r1, ldTab[$urandom_range(0, 4)], d, 7'h03);
            3: return encS(im, r2, r1, 3'($urandom_range(0, 2)));
            4: return encB({im, 1'b0}, r2, r1, 3'($urandom_range(0, 1)));
            5: return encJ({im[11:0], 9'($urandom), 1'b0} >> 0, d);
            6: return encI(im, r1, 3'd0, d, 7'h67);
            7: return {20'($urandom), d, 7'h37};
            default: begin
                op = 7'($urandom);
                while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
                       op == 7'h63 || op == 7'h6F || op == 7'h67 || op == 7'h37)
                    op = 7'($urandom);
                return {25'($urandom), op};
            end
        endcase
    endfunction

    initial begin
        rst = 1'b1; instr_valid = 1'b1; instr = 32'h002081B3;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_ready", {31'd0, instr_ready}, 32'd0);
            checkOutput("rst_strobes", {28'd0, regFileWen, MemWrite, pc_en, illegal}, 32'd0);
            checkOutput("rst_imm", ImmOp, 32'd0);
            checkOutput("rst_fields", {17'd0, rs1, rs2, rd}, 32'd0);
            checkOutput("rst_ctrl", {23'd0, ALU_ctrl, ALUSrc, dataType, SrcSel, JumpSel}, 32'd0);
        end
        rst = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        applyStimulus(encR(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b0);
        applyStimulus(encB(13'h1FF8, 5'd2, 5'd1, 3'd0), 1'b1);
        checkOutput("beq_imm_const", ImmOp, 32'hFFFFFFF8);
        applyStimulus(encB(13'h1FF8, 5'd2, 5'd1, 3'd0), 1'b0);
        applyStimulus(encB(13'h0010, 5'd4, 5'd3, 3'd1), 1'b0);
        applyStimulus(encS(12'd3, 5'd5, 5'd6, 3'd0), 1'b0);
        applyStimulus(encI(12'd4, 5'd6, 3'd2, 5'd7, 7'h03), 1'b0);
        applyStimulus(encJ(21'd16, 5'd1), 1'b0);
        applyStimulus(encI(12'd0, 5'd1, 3'd0, 5'd0, 7'h67), 1'b0);
        applyStimulus(32'h0000007F, 1'b0);
        applyStimulus({20'hABCDE, 5'd9, 7'h37}, 1'b0);

        // Reset arrives while a store sits in MEM: no write may escape.
        curInstr = encS(12'd8, 5'd2, 5'd3, 3'd2);
        instr = curInstr; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        checkOutput("abort_pc_en", {31'd0, pc_en}, 32'd0);
        @(negedge clk);
        checkOutput("abort_memwrite2", {31'd0, MemWrite}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("abort_idle", {31'd0, instr_ready}, 32'd1);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(randomInstr(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
